// File: rtl/regfile_pkg.sv
// Shared register-file types and sizes, also used by the destination-select mux
// and the decode stage.
package regfile_pkg;

   localparam int DATA_W   = 16;
   localparam int ADDR_W   = 3;
   localparam int NUM_REGS = 2 ** ADDR_W;

   typedef logic [ADDR_W-1:0] reg_addr_t;
   typedef logic [DATA_W-1:0] reg_data_t;

endpackage

// File: rtl/reg_scoreboard.sv
// Pending-load scoreboard: one bit per register, set by an issued load and
// cleared by a write, with a pending lookup for each read port.
import regfile_pkg::*;

module reg_scoreboard (
   input  logic      clk,
   input  logic      rst,
   input  logic      i_set_en,
   input  reg_addr_t i_set_addr,
   input  logic      i_clr_en,
   input  reg_addr_t i_clr_addr,
   input  reg_addr_t i_rs_addr,
   input  reg_addr_t i_rt_addr,
   output logic      o_rs_pend,
   output logic      o_rt_pend
);

   logic [NUM_REGS-1:0] r_pend;

   // The set is placed after the clear so that a load issued together with a
   // write to the same register leaves that register pending.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pend <= '0;
      end else begin
         if (i_clr_en) r_pend[i_clr_addr] <= 1'b0;
         if (i_set_en) r_pend[i_set_addr] <= 1'b1;
      end
   end

   assign o_rs_pend = r_pend[i_rs_addr];
   assign o_rt_pend = r_pend[i_rt_addr];

endmodule

// File: rtl/reg_file_wb.sv
// 8-entry register file with a registered write-back stage, two bypassed
// combinational read ports, and a read-after-load stall.
import regfile_pkg::*;

module reg_file_wb (
   input  logic      clk,
   input  logic      rst,
   input  reg_addr_t dst,
   input  logic      wr_en,
   input  reg_data_t wr_data,
   input  logic      ld_issue,
   input  reg_addr_t rs_addr,
   input  reg_addr_t rt_addr,
   input  logic      rs_used,
   input  logic      rt_used,
   output reg_data_t rs_data,
   output reg_data_t rt_data,
   output logic      stall,
   output logic      wb_valid
);

   reg_data_t r_array [NUM_REGS];
   logic      r_wb_valid;
   reg_addr_t r_wb_addr;
   reg_data_t r_wb_data;

   logic      w_rs_hit;
   logic      w_rt_hit;
   logic      w_rs_pend;
   logic      w_rt_pend;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wb_valid <= 1'b0;
         r_wb_addr  <= '0;
         r_wb_data  <= '0;
      end else begin
         r_wb_valid <= wr_en;
         r_wb_addr  <= dst;
         r_wb_data  <= wr_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            r_array[i] <= '0;
         end
      end else if (r_wb_valid) begin
         r_array[r_wb_addr] <= r_wb_data;
      end
   end

   assign w_rs_hit = wr_en && (dst == rs_addr);
   assign w_rt_hit = wr_en && (dst == rt_addr);

   // The incoming write is newer than the one in write-back, which is newer than the array.
   always_comb begin
      rs_data = r_array[rs_addr];
      if (w_rs_hit) begin
         rs_data = wr_data;
      end else if (r_wb_valid && (r_wb_addr == rs_addr)) begin
         rs_data = r_wb_data;
      end
   end

   always_comb begin
      rt_data = r_array[rt_addr];
      if (w_rt_hit) begin
         rt_data = wr_data;
      end else if (r_wb_valid && (r_wb_addr == rt_addr)) begin
         rt_data = r_wb_data;
      end
   end

   reg_scoreboard u_scoreboard (
      .clk        (clk),
      .rst        (rst),
      .i_set_en   (ld_issue),
      .i_set_addr (dst),
      .i_clr_en   (wr_en),
      .i_clr_addr (dst),
      .i_rs_addr  (rs_addr),
      .i_rt_addr  (rt_addr),
      .o_rs_pend  (w_rs_pend),
      .o_rt_pend  (w_rt_pend)
   );

   // A write landing in the same cycle satisfies the consumer through the bypass.
   assign stall = (rs_used && w_rs_pend && !w_rs_hit) ||
                  (rt_used && w_rt_pend && !w_rt_hit);

   assign wb_valid = r_wb_valid;

endmodule

// File: tb/tb_reg_file_wb.sv
// Directed-vector bench for reg_file_wb; expected responses are queued at
// stimulus time and compared by an independent monitor.
module tb_reg_file_wb;

   logic        clk;
   logic        rst;
   logic [2:0]  dst;
   logic        wr_en;
   logic [15:0] wr_data;
   logic        ld_issue;
   logic [2:0]  rs_addr;
   logic [2:0]  rt_addr;
   logic        rs_used;
   logic        rt_used;
   logic [15:0] rs_data;
   logic [15:0] rt_data;
   logic        stall;
   logic        wb_valid;

   typedef struct packed {
      int          id;
      logic [15:0] rs;
      logic [15:0] rt;
      logic        stall;
      logic        wbv;
   } expect_t;

   expect_t expQ[$];
   int      vectorsApplied = 0;
   int      miscompares    = 0;
   int      nextId         = 0;
   event    sampleEv;

   reg_file_wb dut (
      .clk      (clk),
      .rst      (rst),
      .dst      (dst),
      .wr_en    (wr_en),
      .wr_data  (wr_data),
      .ld_issue (ld_issue),
      .rs_addr  (rs_addr),
      .rt_addr  (rt_addr),
      .rs_used  (rs_used),
      .rt_used  (rt_used),
      .rs_data  (rs_data),
      .rt_data  (rt_data),
      .stall    (stall),
      .wb_valid (wb_valid)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Sample points: the falling edge, and 2 time units before each rising edge.
   initial begin
      forever begin
         @(negedge clk);
         ->sampleEv;
         #3;
         ->sampleEv;
      end
   end

   task automatic checkOutput(input string field, input int id,
                              input logic [15:0] got, input logic [15:0] want);
      if (got !== want) begin
         miscompares++;
         $display("[TB] FAIL vec%0d %s: got %h, expected %h", id, field, got, want);
      end
   endtask

   initial begin
      expect_t e;
      forever begin
         @(sampleEv);
         if (expQ.size() != 0) begin
            e = expQ.pop_front();
            vectorsApplied++;
            checkOutput("rs_data",  e.id, rs_data, e.rs);
            checkOutput("rt_data",  e.id, rt_data, e.rt);
            checkOutput("stall",    e.id, {15'd0, stall}, {15'd0, e.stall});
            checkOutput("wb_valid", e.id, {15'd0, wb_valid}, {15'd0, e.wbv});
         end
      end
   end

   task automatic pushExpect(input logic [15:0] expRs, input logic [15:0] expRt,
                             input logic expStall, input logic expWbv);
      expect_t e;
      e.id    = nextId;
      e.rs    = expRs;
      e.rt    = expRt;
      e.stall = expStall;
      e.wbv   = expWbv;
      nextId++;
      expQ.push_back(e);
   endtask

   // One cycle of inputs, driven just after the rising edge.
   task automatic applyStimulus(input logic w, input logic [2:0] d, input logic [15:0] data,
                                input logic ld, input logic [2:0] rsA, input logic [2:0] rtA,
                                input logic rsU, input logic rtU,
                                input logic [15:0] expRs, input logic [15:0] expRt,
                                input logic expStall, input logic expWbv);
      @(posedge clk);
      #1;
      rst      = 1'b0;
      wr_en    = w;
      dst      = d;
      wr_data  = data;
      ld_issue = ld;
      rs_addr  = rsA;
      rt_addr  = rtA;
      rs_used  = rsU;
      rt_used  = rtU;
      pushExpect(expRs, expRt, expStall, expWbv);
   endtask

   // Raise reset between edges; outputs must clear before the next rising edge.
   task automatic applyResetMid();
      @(negedge clk);
      #1;
      rst = 1'b1;
      pushExpect(16'h0000, 16'h0000, 1'b0, 1'b0);
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst = 1'b1; wr_en = 1'b0; dst = 3'd0; wr_data = 16'h0; ld_issue = 1'b0;
      rs_addr = 3'd0; rt_addr = 3'd0; rs_used = 1'b0; rt_used = 1'b0;

      applyResetMid();

      for (int i = 0; i < 8; i++) begin
         applyStimulus(1'b0, 3'd0, 16'h0, 1'b0, 3'(i), 3'(7 - i), 1'b1, 1'b1,
                       16'h0000, 16'h0000, 1'b0, 1'b0);
      end

      // Same-cycle bypass, then write-back bypass, then array.
      applyStimulus(1'b1, 3'd3, 16'hBEEF, 1'b0, 3'd3, 3'd0, 1'b0, 1'b0, 16'hBEEF, 16'h0000, 1'b0, 1'b0);
      applyStimulus(1'b0, 3'd0, 16'h0000, 1'b0, 3'd3, 3'd3, 1'b0, 1'b0, 16'hBEEF, 16'hBEEF, 1'b0, 1'b1);
      applyStimulus(1'b0, 3'd0, 16'h0000, 1'b0, 3'd3, 3'd3, 1'b0, 1'b0, 16'hBEEF, 16'hBEEF, 1'b0, 1'b0);

      // Back-to-back writes to register 5.
      applyStimulus(1'b1, 3'd5, 16'h1111, 1'b0, 3'd3, 3'd5, 1'b0, 1'b0, 16'hBEEF, 16'h1111, 1'b0, 1'b0);
      applyStimulus(1'b1, 3'd5, 16'h2222, 1'b0, 3'd5, 3'd5, 1'b0, 1'b0, 16'h2222, 16'h2222, 1'b0, 1'b1);
      applyStimulus(1'b0, 3'd0, 16'h0000, 1'b0, 3'd5, 3'd5, 1'b0, 1'b0, 16'h2222, 16'h2222, 1'b0, 1'b1);
      applyStimulus(1'b0, 3'd0, 16'h0000, 1'b0, 3'd5, 3'd5, 1'b0, 1'b0, 16'h2222, 16'h2222, 1'b0, 1'b0);

      // Load to register 2, stall on use, resolved by a write.
      applyStimulus(1'b0, 3'd2, 16'h0000, 1'b1, 3'd2, 3'd3, 1'b1, 1'b0, 16'h0000, 16'hBEEF, 1'b0, 1'b0);
      applyStimulus(1'b0, 3'd0, 16'h0000, 1'b0, 3'd2, 3'd3, 1'b1, 1'b0, 16'h0000, 16'hBEEF, 1'b1, 1'b0);
      applyStimulus(1'b0, 3'd0, 16'h0000, 1'b0, 3'd2, 3'd3, 1'b0, 1'b0, 16'h0000, 16'hBEEF, 1'b0, 1'b0);
      applyStimulus(1'b1, 3'd2, 16'h00AA, 1'b0, 3'd2, 3'd3, 1'b1, 1'b0, 16'h00AA, 16'hBEEF, 1'b0, 1'b0);
      applyStimulus(1'b0, 3'd0, 16'h0000, 1'b0, 3'd2, 3'd3, 1'b1, 1'b0, 16'h00AA, 16'hBEEF, 1'b0, 1'b1);

      // Load and write to register 6 together: the load stays pending.
      applyStimulus(1'b1, 3'd6, 16'h6666, 1'b1, 3'd0, 3'd6, 1'b0, 1'b1, 16'h0000, 16'h6666, 1'b0, 1'b0);
      applyStimulus(1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 3'd6, 1'b0, 1'b1, 16'h0000, 16'h6666, 1'b1, 1'b1);

      // In-flight write and pending load, then asynchronous reset mid-cycle.
      applyStimulus(1'b0, 3'd4, 16'h0000, 1'b1, 3'd1, 3'd4, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
      applyStimulus(1'b1, 3'd1, 16'h7777, 1'b0, 3'd1, 3'd4, 1'b0, 1'b1, 16'h7777, 16'h0000, 1'b1, 1'b0);
      applyStimulus(1'b0, 3'd0, 16'h0000, 1'b0, 3'd1, 3'd4, 1'b0, 1'b1, 16'h7777, 16'h0000, 1'b1, 1'b1);
      applyResetMid();
      applyStimulus(1'b0, 3'd0, 16'h0000, 1'b0, 3'd1, 3'd4, 1'b1, 1'b1, 16'h0000, 16'h0000, 1'b0, 1'b0);
      applyStimulus(1'b0, 3'd0, 16'h0000, 1'b0, 3'd1, 3'd6, 1'b1, 1'b1, 16'h0000, 16'h0000, 1'b0, 1'b0);
      applyStimulus(1'b0, 3'd0, 16'h0000, 1'b0, 3'd3, 3'd2, 1'b1, 1'b1, 16'h0000, 16'h0000, 1'b0, 1'b0);

      repeat (3) @(posedge clk);
      if (expQ.size() != 0) begin
         miscompares++;
         $display("[TB] FAIL drain: %0d expectations left unchecked, expected 0", expQ.size());
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
      $finish;
   end

endmodule
